// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI frame constants and receiver state encoding
package spi_pkg;

  localparam int SPI_FRAME_BITS = 16;
  localparam int SPI_DATA_W     = 15;
  localparam int SPI_PAD_IDX    = 8;

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    IDLE  = 2'd1,
    SHIFT = 2'd2,
    CHECK = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_rd_if.sv
// rtl/spi_rd_if.sv - SPI pin and receive-result bundle for spi_rd
interface spi_rd_if #(
  parameter int DATA_W = spi_pkg::SPI_DATA_W
);

  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic [DATA_W-1:0] data_rx;
  logic              valid;
  logic              frame_err;
  logic              busy;

  // Bus side that drives the SPI pins and watches the receiver results
  modport master (
    output sclk, cs_n, mosi,
    input  data_rx, valid, frame_err, busy
  );

  // Receiver side
  modport slave (
    input  sclk, cs_n, mosi,
    output data_rx, valid, frame_err, busy
  );

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage synchroniser with rise/fall edge pulses
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  // Shift the raw pin into the chain; the extra flop remembers the last synced level
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  // Chain and edge flop are preset to the idle pin level so reset creates no false edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_rd.sv
// rtl/spi_rd.sv - oversampled SPI slave receiver that strips the stuffed pad bit
module spi_rd
  import spi_pkg::*;
#(
  parameter int FRAME_BITS  = SPI_FRAME_BITS,
  parameter int DATA_W      = SPI_DATA_W,
  parameter int PAD_IDX     = SPI_PAD_IDX,
  parameter int SYNC_STAGES = 2
) (
  input logic     clk,
  input logic     rst,
  spi_rd_if.slave bus
);

  // Pad bit position inside the shift register once the whole frame has arrived
  localparam int             PAD_POS   = FRAME_BITS - 1 - PAD_IDX;
  localparam logic [5:0]     FRAME_CNT = 6'(FRAME_BITS);
  localparam int             ARM_W     = $clog2(SYNC_STAGES + 1);
  localparam logic [ARM_W-1:0] ARM_FLUSH = ARM_W'(SYNC_STAGES);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic unused_sclk;
  logic mosi_s;

  spi_state_e              state_q, state_d;
  logic [5:0]              bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]       data_rx_q, data_rx_d;
  logic                    valid_q, valid_d;
  logic                    frame_err_q, frame_err_d;
  logic                    pend_q, pend_d;
  logic [ARM_W-1:0]        arm_cnt_q, arm_cnt_d;
  logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.sclk),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.cs_n),
    .level (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // Only the sclk rising edge matters; level and falling edge are left over
  assign unused_sclk = sclk_lvl ^ sclk_fall;

  // mosi needs a level only, kept at the same depth as sclk so data and edge line up
  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
  end

  // mosi synchroniser
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mosi_sync_q <= '0;
    else      mosi_sync_q <= mosi_sync_d;
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Drop the pad bit and pack the remaining bits in arrival order
  function automatic logic [DATA_W-1:0] strip_pad(input logic [FRAME_BITS-1:0] s);
    logic [DATA_W-1:0] r;
    int                k;
    r = '0;
    k = 0;
    for (int i = 0; i < FRAME_BITS; i++) begin
      if (i != PAD_POS) begin
        r[k] = s[i];
        k++;
      end
    end
    return r;
  endfunction

  // Frame FSM: next state, shift/count, judgement and result pulses
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    data_rx_d   = data_rx_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    pend_d      = pend_q;
    arm_cnt_d   = arm_cnt_q;
    case (state_q)
      ARM: begin
        // The preset synchroniser value must flush before cs_n level is trusted
        pend_d = 1'b0;
        if (arm_cnt_q != ARM_FLUSH) arm_cnt_d = arm_cnt_q + 1'b1;
        else if (cs_lvl)            state_d   = IDLE;
      end
      IDLE: begin
        if (cs_fall || pend_q) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          shreg_d   = '0;
          pend_d    = 1'b0;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], mosi_s};
          if (bit_cnt_q != 6'd63) bit_cnt_d = bit_cnt_q + 6'd1;
        end
        if (cs_rise) state_d = CHECK;
      end
      CHECK: begin
        state_d = IDLE;
        if (bit_cnt_q == FRAME_CNT && !shreg_q[PAD_POS]) begin
          data_rx_d = strip_pad(shreg_q);
          valid_d   = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
        // A new frame starting right now is remembered for IDLE
        if (cs_fall) pend_d = 1'b1;
      end
      default: state_d = ARM;
    endcase
  end

  // Frame FSM and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARM;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      data_rx_q   <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      pend_q      <= 1'b0;
      arm_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      data_rx_q   <= data_rx_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      pend_q      <= pend_d;
      arm_cnt_q   <= arm_cnt_d;
    end
  end

  assign bus.data_rx   = data_rx_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q == SHIFT);

endmodule
